// File: rtl/convolution_filter_pkg.sv
// conv_pkg: shared sizes, types and output saturation for the 5x5 convolution filter
package conv_pkg;
  localparam int COEFF_WIDTH = 16;
  localparam int KSIZE = 5;
  localparam int NTAPS = KSIZE * KSIZE;
  localparam int FRAC_BITS = 8;
  localparam int LAT_PIPE = 3;
  localparam int PIX_W = 8;
  localparam int DIM_W = 10;
  localparam int PROD_W = PIX_W + 1 + COEFF_WIDTH;
  localparam int ACC_W = 32;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  function automatic pix_t sat8(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    s = acc >>> FRAC_BITS;
    return s < 0 ? '0 : (s > 255 ? 8'hff : s[PIX_W-1:0]);
  endfunction
endpackage

// File: rtl/convolution_filter_if.sv
// conv_if: kernel config and raster pixel stream bus of the convolution filter
interface conv_if;
  import conv_pkg::*;
  logic io_config_load;
  coeff_t io_coeff_in;
  logic [DIM_W-1:0] io_image_width;
  logic [DIM_W-1:0] io_image_height;
  logic io_frame_sync_in;
  pix_t io_data_in;
  logic io_frame_sync_out;
  pix_t io_data_out;
  modport master(
    output io_config_load, io_coeff_in, io_image_width, io_image_height, io_frame_sync_in, io_data_in,
    input io_frame_sync_out, io_data_out
  );
  modport slave(
    input io_config_load, io_coeff_in, io_image_width, io_image_height, io_frame_sync_in, io_data_in,
    output io_frame_sync_out, io_data_out
  );
endinterface

// File: rtl/convolution_filter_line_buffer.sv
// conv_line_buffer: four column-addressed line stores that shift each column down one row per pixel
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int MAX_WIDTH = 1024
) (
  input  logic clk,
  input  logic [DIM_W-1:0] i_addr,
  input  pix_t i_pix,
  output pix_t o_taps [KSIZE-1]
);
  pix_t r_mem [KSIZE-1][MAX_WIDTH];
  always_comb
    for (int k = 0; k < KSIZE-1; k++) o_taps[k] = r_mem[k][i_addr];
  always_ff @(posedge clk) begin
    r_mem[0][i_addr] <= i_pix;
    for (int k = 1; k < KSIZE-1; k++) r_mem[k][i_addr] <= r_mem[k-1][i_addr];
  end
endmodule

// File: rtl/convolution_filter.sv
// convolution_filter: streaming 5x5 zero-padded correlation on 8-bit raster frames, one pixel per clock
module convolution_filter
  import conv_pkg::*;
#(
  parameter int MAX_WIDTH = 1024
) (
  input logic clk,
  input logic reset,
  conv_if.slave io
);
  coeff_t r_k [NTAPS];
  logic [4:0] r_idx;
  logic [DIM_W-1:0] r_row, r_col, r_w, r_h, r_crow, r_ccol, r_cw, r_ch;
  logic [DIM_W-1:0] w_row, w_col, w_w, w_h, w_crow, w_ccol, w_cw, w_ch;
  logic r_pend, r_cact, w_pend, w_cstart, w_cact;
  pix_t w_taps [KSIZE-1];
  pix_t w_colv [KSIZE];
  pix_t w_win [KSIZE][KSIZE];
  pix_t r_win [KSIZE][KSIZE-1];
  pix_t w_px [NTAPS];
  prod_t r_prod [NTAPS];
  logic signed [ACC_W-1:0] w_acc, r_sum;
  logic r_v1, r_s1, r_v2, r_s2, r_s3;
  pix_t r_out;
  conv_line_buffer #(.MAX_WIDTH(MAX_WIDTH)) u_lb (
    .clk(clk),
    .i_addr(w_col),
    .i_pix(io.io_data_in),
    .o_taps(w_taps)
  );
  always_comb begin
    w_row = io.io_frame_sync_in ? '0 : r_row;
    w_col = io.io_frame_sync_in ? '0 : r_col;
    w_w = io.io_frame_sync_in ? io.io_image_width : r_w;
    w_h = io.io_frame_sync_in ? io.io_image_height : r_h;
    w_pend = io.io_frame_sync_in | r_pend;
    w_cstart = w_pend && w_row == DIM_W'(2) && w_col == DIM_W'(2);
    w_cact = w_cstart | r_cact;
    w_crow = w_cstart ? '0 : r_crow;
    w_ccol = w_cstart ? '0 : r_ccol;
    w_cw = w_cstart ? w_w : r_cw;
    w_ch = w_cstart ? w_h : r_ch;
  end
  always_comb begin
    w_colv[KSIZE-1] = io.io_data_in;
    for (int k = 0; k < KSIZE-1; k++) w_colv[KSIZE-2-k] = w_taps[k];
  end
  always_comb
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE-1; j++) w_win[i][j] = r_win[i][j];
      w_win[i][KSIZE-1] = w_colv[i];
    end
  always_comb
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE; j++)
        w_px[i*KSIZE+j] = (w_cact && int'(w_crow) + i >= 2 && int'(w_crow) + i <= int'(w_ch) + 2 &&
                           int'(w_ccol) + j >= 2 && int'(w_ccol) + j <= int'(w_cw) + 2) ? w_win[i][j] : '0;
  always_comb begin
    w_acc = '0;
    for (int n = 0; n < NTAPS; n++) w_acc = w_acc + ACC_W'(r_prod[n]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_idx <= '0;
      for (int n = 0; n < NTAPS; n++) r_k[n] <= '0;
    end else begin
      if (io.io_config_load) r_k[r_idx] <= io.io_coeff_in;
      r_idx <= io.io_config_load && r_idx != 5'(NTAPS-1) ? r_idx + 1'b1 : '0;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
      r_w <= '0;
      r_h <= '0;
      r_pend <= 1'b0;
      r_crow <= '0;
      r_ccol <= '0;
      r_cw <= '0;
      r_ch <= '0;
      r_cact <= 1'b0;
      r_v1 <= 1'b0;
      r_s1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_out <= '0;
    end else begin
      r_row <= w_col == w_w ? w_row + 1'b1 : w_row;
      r_col <= w_col == w_w ? '0 : w_col + 1'b1;
      r_w <= w_w;
      r_h <= w_h;
      r_pend <= w_pend && !w_cstart;
      r_crow <= w_ccol == w_cw ? w_crow + 1'b1 : w_crow;
      r_ccol <= w_ccol == w_cw ? '0 : w_ccol + 1'b1;
      r_cw <= w_cw;
      r_ch <= w_ch;
      r_cact <= w_cact && !(w_ccol == w_cw && w_crow == w_ch);
      r_v1 <= w_cact;
      r_s1 <= w_cstart;
      r_v2 <= r_v1;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_out <= r_v2 ? sat8(r_sum) : '0;
    end
  always_ff @(posedge clk) begin
    for (int i = 0; i < KSIZE; i++)
      for (int j = 0; j < KSIZE-1; j++) r_win[i][j] <= w_win[i][j+1];
    for (int n = 0; n < NTAPS; n++) r_prod[n] <= PROD_W'($signed({1'b0, w_px[n]})) * PROD_W'(r_k[n]);
    r_sum <= w_acc;
  end
  assign io.io_data_out = r_out;
  assign io.io_frame_sync_out = r_s3;
endmodule

// File: tb/tb_convolution_filter.sv
// tb_convolution_filter: scoreboard bench driving directed frames through the convolution filter
module tb_convolution_filter;
  import conv_pkg::*;
  typedef struct {int npix; int sync_cyc;} frm_t;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit ignore = 0;
  int kern [NTAPS];
  int img [];
  int cap [];
  int exp_q [$];
  frm_t frm_q [$];
  conv_if dif();
  convolution_filter dut(.clk(clk), .reset(reset), .io(dif));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int model(int r, int c, int w, int h);
    longint acc = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (r+i-2 >= 0 && r+i-2 < h && c+j-2 >= 0 && c+j-2 < w)
          acc += longint'(kern[5*i+j]) * img[(r+i-2)*w + c+j-2];
    acc = acc >>> 8;
    return acc < 0 ? 0 : (acc > 255 ? 255 : int'(acc));
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      dif.io_data_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
  endtask
  task automatic load_kernel(input int centre, input int rest);
    for (int n = 0; n < NTAPS; n++) begin
      kern[n] = n == 12 ? centre : rest;
      dif.io_config_load = 1;
      dif.io_coeff_in = 16'(kern[n]);
      @(posedge clk); #1;
    end
    dif.io_config_load = 0;
  endtask
  task automatic run_frame(input int w, input int h, input int cval, input bit chk, input int abort);
    img = new[w*h];
    foreach (img[p]) img[p] = cval < 0 ? int'($urandom_range(0, 255)) : cval;
    if (chk) begin
      frm_q.push_back('{w*h, cyc + 2*w + 2 + LAT_PIPE});
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) exp_q.push_back(model(r, c, w, h));
    end
    dif.io_image_width = 10'(w-1);
    dif.io_image_height = 10'(h-1);
    for (int p = 0; p < w*h && p != abort; p++) begin
      dif.io_frame_sync_in = p == 0;
      dif.io_data_in = 8'(img[p]);
      @(posedge clk); #1;
    end
    dif.io_frame_sync_in = 0;
  endtask
  task automatic check_pt(input int r, input int c, input int want);
    total++;
    if (cap[r*128+c] != want) begin
      bad++;
      $display("FAIL box(%0d,%0d): got %0d want %0d", r, c, cap[r*128+c], want);
    end
  endtask
  initial begin
    int rem, pos, e;
    frm_t f;
    rem = 0;
    pos = 0;
    forever begin
      @(negedge clk);
      if (ignore) rem = 0;
      else begin
        if (dif.io_frame_sync_out) begin
          total++;
          if (rem != 0 || frm_q.size() == 0) begin
            bad++;
            $display("FAIL sync_out: unexpected pulse at cycle %0d with %0d pixels outstanding, want none", cyc, rem);
          end else begin
            f = frm_q.pop_front();
            rem = f.npix;
            pos = 0;
            total++;
            if (cyc != f.sync_cyc) begin
              bad++;
              $display("FAIL sync_latency: pulse at cycle %0d want %0d", cyc, f.sync_cyc);
            end
          end
        end
        if (rem > 0) begin
          e = exp_q.pop_front();
          total++;
          if (int'(dif.io_data_out) != e) begin
            bad++;
            $display("FAIL pixel %0d: got %0d want %0d", pos, dif.io_data_out, e);
          end
          cap[pos] = int'(dif.io_data_out);
          pos++;
          rem--;
        end else begin
          total++;
          if (dif.io_data_out != 0) begin
            bad++;
            $display("FAIL idle_zero: got %0d want 0 at cycle %0d", dif.io_data_out, cyc);
          end
        end
      end
    end
  end
  initial begin
    cap = new[16384];
    dif.io_config_load = 0;
    dif.io_coeff_in = 0;
    dif.io_image_width = 0;
    dif.io_image_height = 0;
    dif.io_frame_sync_in = 0;
    dif.io_data_in = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    idle(3);
    load_kernel(256, 0);
    run_frame(128, 128, -1, 1, -1);
    idle(300);
    load_kernel(16, 16);
    run_frame(128, 128, 16, 1, -1);
    idle(300);
    check_pt(64, 64, 25);
    check_pt(0, 0, 9);
    check_pt(0, 64, 15);
    check_pt(1, 1, 16);
    check_pt(127, 127, 9);
    load_kernel(-256, 0);
    run_frame(16, 16, 200, 1, -1);
    idle(60);
    load_kernel(256, 256);
    run_frame(16, 16, 200, 1, -1);
    idle(60);
    load_kernel(256, 0);
    run_frame(64, 64, -1, 1, -1);
    run_frame(64, 64, -1, 1, -1);
    idle(300);
    run_frame(8, 4, -1, 1, -1);
    idle(60);
    ignore = 1;
    run_frame(128, 128, -1, 0, 5000);
    reset = 0;
    ignore = 0;
    idle(3);
    reset = 1;
    idle(2);
    foreach (kern[n]) kern[n] = 0;
    run_frame(8, 4, -1, 1, -1);
    idle(40);
    load_kernel(256, 0);
    run_frame(8, 4, -1, 1, -1);
    idle(60);
    total++;
    if (frm_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d frames and %0d pixels still expected, want 0 and 0", frm_q.size(), exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
